csa_accumulator: RTL and testbench

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

---
 rtl/csa_acc_pkg.sv | 15 +
 rtl/csa_row.sv | 17 +
 rtl/csa_accumulator.sv | 132 +++++++++++++
 tb/tb_csa_accumulator.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/csa_acc_pkg.sv
// Shared types and default sizing for the carry-save packet accumulator.
package csa_acc_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_GUARD = 4;
   localparam int DEF_CHUNK = 4;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      RESOLVE,
      OUT
   } state_t;

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 compressors: per-bit full adders with the carry left unshifted.
module csa_row #(
   parameter int W = 20
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign carry[i] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
   end

endmodule

// File: rtl/csa_accumulator.sv
// Packet accumulator: sums beats in carry-save form, then resolves S+C one
// CHUNK-wide slice per cycle before presenting the result.
module csa_accumulator
   import csa_acc_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int GUARD = DEF_GUARD,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH+GUARD-1:0] out_data,
   output logic                   out_ovf,
   output logic                   busy
);

   localparam int AW = WIDTH + GUARD;
   localparam int N  = AW / CHUNK;
   localparam int CW = $clog2(N + 1);

   state_t          state_q, state_d;
   logic [AW-1:0]   s_q, s_d;
   logic [AW-1:0]   c_q, c_d;
   logic            carry_q, carry_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic [AW-1:0]   out_data_q, out_data_d;

   logic            accept;
   logic [AW-1:0]   x_ext;
   logic [AW-1:0]   row_sum;
   logic [AW-1:0]   row_carry;
   logic [CHUNK:0]  chunk_sum;

   assign x_ext  = AW'(in_data);
   assign accept = in_valid & in_ready;

   csa_row #(.W(AW)) u_row (
      .a     (s_q),
      .b     (c_q),
      .c     (x_ext),
      .sum   (row_sum),
      .carry (row_carry)
   );

   // The only carry-propagate path: one CHUNK-wide slice plus the carry flop.
   assign chunk_sum = {1'b0, s_q[CHUNK-1:0]} + {1'b0, c_q[CHUNK-1:0]}
                      + (CHUNK+1)'(carry_q);

   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      c_d        = c_q;
      carry_d    = carry_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      out_data_d = out_data_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               s_d     = x_ext;
               c_d     = '0;
               ovf_d   = 1'b0;
               carry_d = 1'b0;
               cnt_d   = '0;
               state_d = in_last ? RESOLVE : ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               s_d     = row_sum;
               c_d     = {row_carry[AW-2:0], 1'b0};
               ovf_d   = ovf_q | row_carry[AW-1];
               carry_d = 1'b0;
               cnt_d   = '0;
               if (in_last) state_d = RESOLVE;
            end
         end
         RESOLVE: begin
            if (cnt_q == CW'(N)) begin
               // S now holds the resolved sum; the carry flop holds the top carry-out.
               out_data_d = s_q;
               ovf_d      = ovf_q | carry_q;
               state_d    = OUT;
            end else begin
               // Rotate resolved slices in from the top so S ends up as the result.
               s_d     = (s_q >> CHUNK) | (AW'(chunk_sum[CHUNK-1:0]) << (AW - CHUNK));
               c_d     = c_q >> CHUNK;
               carry_d = chunk_sum[CHUNK];
               cnt_d   = cnt_q + CW'(1);
            end
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         s_q        <= '0;
         c_q        <= '0;
         carry_q    <= 1'b0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         c_q        <= c_d;
         carry_q    <= carry_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         out_data_q <= out_data_d;
      end
   end

   assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
   assign out_valid = (state_q == OUT);
   assign busy      = (state_q != IDLE);
   assign out_data  = out_data_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Randomized bench for csa_accumulator against an arithmetic packet-sum model.
module tb_csa_accumulator;

   localparam int WIDTH = 16;
   localparam int GUARD = 4;
   localparam int CHUNK = 4;
   localparam int AW    = WIDTH + GUARD;
   localparam int N     = AW / CHUNK;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [AW-1:0]    out_data;
   logic             out_ovf;
   logic             busy;

   int               cyc = 0;
   int               acc_cyc = 0;
   int               n_checks = 0;
   int               n_errors = 0;
   int unsigned      beats[$];

   csa_accumulator #(.WIDTH(WIDTH), .GUARD(GUARD), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Offer each beat of the queue, with random idle gaps carrying junk.
   task automatic send_packet(input int gap_pct);
      for (int i = 0; i < beats.size(); i++) begin
         bit done = 1'b0;
         int tries = 0;
         logic rdy;
         while (!done && tries < 100) begin
            @(negedge clk);
            tries++;
            if ($urandom_range(0, 99) < gap_pct) begin
               in_valid = 1'b0;
               in_data  = WIDTH'($urandom);
               in_last  = 1'($urandom);
            end else begin
               in_valid = 1'b1;
               in_data  = WIDTH'(beats[i]);
               in_last  = (i == beats.size() - 1);
               rdy      = in_ready;
               @(posedge clk);
               #1;
               if (rdy) begin
                  done    = 1'b1;
                  acc_cyc = cyc;
               end
            end
         end
         if (!done) check_eq("in_ready_timeout", in_ready, 1);
      end
   endtask

   task automatic wait_result(input int hold, input bit noise, input string tag);
      longint        sum = 0;
      logic [AW-1:0] exp_data;
      logic          exp_ovf;
      int            waited = 0;
      foreach (beats[i]) sum += longint'(beats[i]);
      exp_data = AW'(sum);
      exp_ovf  = (sum >= (longint'(1) << AW));
      do begin
         @(negedge clk);
         in_valid = noise ? 1'($urandom) : 1'b0;
         in_data  = WIDTH'($urandom);
         in_last  = 1'($urandom);
         waited++;
      end while (!out_valid && waited < 50);
      check_eq({tag, "_valid"}, out_valid, 1);
      check_eq({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(N + 1));
      check_eq({tag, "_data"}, out_data, exp_data);
      check_eq({tag, "_ovf"}, out_ovf, exp_ovf);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         in_valid = noise ? 1'($urandom) : 1'b0;
         in_data  = WIDTH'($urandom);
         check_eq({tag, "_hold_valid"}, out_valid, 1);
         check_eq({tag, "_hold_data"}, out_data, exp_data);
         check_eq({tag, "_hold_ovf"}, out_ovf, exp_ovf);
         check_eq({tag, "_hold_in_ready"}, in_ready, 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check_eq({tag, "_in_ready_after"}, in_ready, 1);
      check_eq({tag, "_out_valid_after"}, out_valid, 0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset_in_ready", in_ready, 1);
      check_eq("reset_out_valid", out_valid, 0);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_out_data", out_data, 0);
      check_eq("reset_out_ovf", out_ovf, 0);
      rst = 1'b0;

      beats = {3, 5, 7};
      send_packet(0);
      wait_result(0, 1'b0, "three_beats");

      beats = {16'hFFFF};
      send_packet(0);
      wait_result(0, 1'b0, "single_ffff");

      beats.delete();
      repeat (17) beats.push_back(16'hFFFF);
      send_packet(0);
      wait_result(0, 1'b0, "seventeen_ffff");

      beats = {16'h1234, 16'hFFFF, 16'h0009};
      send_packet(0);
      wait_result(10, 1'b1, "backpressure");
      beats = {1, 1};
      send_packet(0);
      wait_result(0, 1'b0, "after_backpressure");

      beats = {100, 200};
      send_packet(0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("pre_reset_busy", busy, 1);
      rst = 1'b1;
      #1;
      check_eq("mid_reset_out_data", out_data, 0);
      check_eq("mid_reset_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("post_reset_out_valid", out_valid, 0);
      check_eq("post_reset_busy", busy, 0);
      check_eq("post_reset_in_ready", in_ready, 1);
      beats = {1, 2};
      send_packet(0);
      wait_result(0, 1'b0, "after_reset");

      beats = {10, 20, 30};
      send_packet(40);
      wait_result(0, 1'b0, "gapped");

      for (int p = 0; p < 25; p++) begin
         int len = $urandom_range(1, 22);
         beats.delete();
         for (int b = 0; b < len; b++) beats.push_back($urandom_range(0, 16'hFFFF));
         send_packet($urandom_range(0, 50));
         wait_result($urandom_range(0, 3), 1'b1, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
